// File: rtl/gpr_file_if.sv
// Register-file port bundle: one one-hot write port, two binary-addressed read ports, sticky select error.
interface gpr_file_if #(
   parameter int DATA_W = 16,
   parameter int NREG   = 16,
   parameter int ADDR_W = 4
);
   logic              we;
   logic [NREG-1:0]   wr_sel;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              sel_err;

   modport master (
      output we, wr_sel, wr_data, rd_addr_a, rd_addr_b,
      input  rd_data_a, rd_data_b, sel_err
   );

   modport slave (
      input  we, wr_sel, wr_data, rd_addr_a, rd_addr_b,
      output rd_data_a, rd_data_b, sel_err
   );
endinterface

// File: rtl/gpr_file.sv
// General-purpose register file: one-hot write select, two registered read ports with
// write-first bypass, and a sticky flag for malformed write selects.
module gpr_file #(
   parameter int DATA_W = 16,
   parameter int NREG   = 16,
   parameter int ADDR_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   gpr_file_if.slave  bus
);

   logic [DATA_W-1:0] regs [NREG];
   logic              sel_onehot;
   logic              wr_ok;
   logic [ADDR_W-1:0] wr_idx;
   logic              byp_a;
   logic              byp_b;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
   assign sel_onehot = (bus.wr_sel != '0) &&
                       ((bus.wr_sel & (bus.wr_sel - NREG'(1))) == '0);
   assign wr_ok      = bus.we && sel_onehot;

   always_comb begin
      wr_idx = '0;
      for (int i = 0; i < NREG; i++) begin
         if (bus.wr_sel[i]) wr_idx = ADDR_W'(i);
      end
   end

   assign byp_a = wr_ok && (wr_idx == bus.rd_addr_a);
   assign byp_b = wr_ok && (wr_idx == bus.rd_addr_b);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[wr_idx] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rd_data_a <= '0;
         bus.rd_data_b <= '0;
         bus.sel_err   <= 1'b0;
      end else begin
         bus.rd_data_a <= byp_a ? bus.wr_data : regs[bus.rd_addr_a];
         bus.rd_data_b <= byp_b ? bus.wr_data : regs[bus.rd_addr_b];
         if (bus.we && !sel_onehot) bus.sel_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: reset, write/read, bypass, bad selects, WE low, reset priority, full fill.
module tb_gpr_file;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   gpr_file_if #(.DATA_W(16), .NREG(16), .ADDR_W(4)) bus ();

   gpr_file #(.DATA_W(16), .NREG(16), .ADDR_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] sel, input logic [15:0] data);
      bus.we      = 1'b1;
      bus.wr_sel  = sel;
      bus.wr_data = data;
      tick();
      bus.we      = 1'b0;
   endtask

   initial begin
      logic [15:0] exp_a;
      logic [15:0] exp_b;
      rst           = 1'b1;
      bus.we        = 1'b0;
      bus.wr_sel    = '0;
      bus.wr_data   = '0;
      bus.rd_addr_a = '0;
      bus.rd_addr_b = '0;
      tick();
      tick();
      rst = 1'b0;

      // 1: reset sweep, port B walks the opposite direction
      chk("rst_sel_err", {15'd0, bus.sel_err}, 16'h0000);
      for (int i = 0; i < 16; i++) begin
         bus.rd_addr_a = 4'(i);
         bus.rd_addr_b = 4'(15 - i);
         tick();
         chk($sformatf("rst_a[%0d]", i), bus.rd_data_a, 16'h0000);
         chk($sformatf("rst_b[%0d]", 15 - i), bus.rd_data_b, 16'h0000);
      end

      // 2: write reg3 then read
      wr(16'h0008, 16'hA5A5);
      bus.rd_addr_a = 4'd3;
      bus.rd_addr_b = 4'd2;
      tick();
      chk("wr_rd_a3", bus.rd_data_a, 16'hA5A5);
      chk("wr_rd_b2", bus.rd_data_b, 16'h0000);

      // 3: bypass on both ports
      bus.rd_addr_a = 4'd15;
      bus.rd_addr_b = 4'd15;
      wr(16'h8000, 16'h1234);
      chk("byp_a15", bus.rd_data_a, 16'h1234);
      chk("byp_b15", bus.rd_data_b, 16'h1234);
      tick();
      chk("hold_a15", bus.rd_data_a, 16'h1234);

      // WE low with a malformed select must not raise the flag
      bus.wr_sel  = 16'h0011;
      bus.wr_data = 16'hFFFF;
      tick();
      chk("we0_no_err", {15'd0, bus.sel_err}, 16'h0000);

      // 4: bad selects, regs 0 and 4 preloaded
      wr(16'h0001, 16'h1111);
      wr(16'h0010, 16'h4444);
      bus.rd_addr_a = 4'd0;
      bus.rd_addr_b = 4'd4;
      wr(16'h0011, 16'hFFFF);
      chk("bad_nobyp_a0", bus.rd_data_a, 16'h1111);
      chk("bad_nobyp_b4", bus.rd_data_b, 16'h4444);
      chk("bad_err_set", {15'd0, bus.sel_err}, 16'h0001);
      for (int i = 0; i < 5; i++) tick();
      chk("bad_err_sticky", {15'd0, bus.sel_err}, 16'h0001);
      chk("bad_reg0", bus.rd_data_a, 16'h1111);
      chk("bad_reg4", bus.rd_data_b, 16'h4444);
      wr(16'h0000, 16'hFFFF);
      tick();
      chk("zero_sel_a0", bus.rd_data_a, 16'h1111);
      chk("zero_sel_b4", bus.rd_data_b, 16'h4444);

      // 5: WE low to reg1
      bus.rd_addr_a = 4'd1;
      bus.wr_sel    = 16'h0002;
      bus.wr_data   = 16'hBEEF;
      tick();
      chk("we0_nobyp_a1", bus.rd_data_a, 16'h0000);
      tick();
      chk("we0_reg1", bus.rd_data_a, 16'h0000);
      chk("we0_err_kept", {15'd0, bus.sel_err}, 16'h0001);

      // 6: reset beats a simultaneous write
      bus.rd_addr_a = 4'd0;
      bus.rd_addr_b = 4'd3;
      rst = 1'b1;
      wr(16'h0001, 16'h5555);
      rst = 1'b0;
      chk("rstp_out_a", bus.rd_data_a, 16'h0000);
      chk("rstp_out_b", bus.rd_data_b, 16'h0000);
      chk("rstp_err", {15'd0, bus.sel_err}, 16'h0000);
      bus.rd_addr_b = 4'd4;
      tick();
      chk("rstp_reg0", bus.rd_data_a, 16'h0000);
      chk("rstp_reg4", bus.rd_data_b, 16'h0000);

      for (int i = 0; i < 16; i++) wr(16'(1 << i), 16'h0100 + 16'(i));
      for (int i = 0; i < 16; i++) begin
         bus.rd_addr_a = 4'(i);
         bus.rd_addr_b = 4'(15 - i);
         exp_a = 16'h0100 + 16'(i);
         exp_b = 16'h0100 + 16'(15 - i);
         tick();
         chk($sformatf("fill_a[%0d]", i), bus.rd_data_a, exp_a);
         chk($sformatf("fill_b[%0d]", 15 - i), bus.rd_data_b, exp_b);
      end
      chk("fill_err", {15'd0, bus.sel_err}, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
